// File: rtl/qea_core.sv
// qea_core: quantum-circuit emulation accelerator. Sweeps 2x2 complex gates
// over an n-qubit Q2.30 state vector held in PE_NUM-lane words.
// Ports: clk, rst (sync, high), i_start, i_qbit_num, ctx write port
// (i_ctx_*), host state port (i_state_*, o_state_dout), o_complete.
// Config: define QEA_SATURATE_EN for saturating products/sums.
module qea_core #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
  parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
  parameter int GATE_ADDR_WIDTH         = 6,
  parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  input  logic                               i_ctx_en,
  input  logic                               i_ctx_wea,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ctx_addr,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0] i_ctx_data,
  input  logic                               i_state_ena,
  input  logic                               i_state_wea,
  input  logic [STATE_ADDR_WIDTH-1:0]        i_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_state_dina,
  output logic                               o_complete,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dout
);
  localparam int DW = ALU_DATA_WIDTH;
  localparam int SW = STATE_DATA_WIDTH;
  localparam int LW = PE_NUM*SW;
  localparam int AW = STATE_ADDR_WIDTH;
  localparam int PW = PE_NUM_WIDTH;
  localparam int IW = AW + PW;
  localparam int CW = GATE_CONTEXT_DATA_WIDTH;
  localparam int CA = GATE_CONTEXT_ADDR_WIDTH;
  localparam int GA = GATE_ADDR_WIDTH;
  localparam int MQ = MAX_QBIT_WIDTH;
  localparam int GW = GATE_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_COEF, S_SWEEP, S_WRB, S_DONE
  } st_t;

  function automatic logic [DW-1:0] fx_mul(
    input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic signed [2*DW-1:0] xs, ys, sh;
    xs = {{DW{x[DW-1]}}, x};
    ys = {{DW{y[DW-1]}}, y};
    sh = (xs * ys) >>> NUM_FRAC_BIT;
`ifdef QEA_SATURATE_EN
    if (sh[2*DW-1:DW-1] != {(DW+1){sh[2*DW-1]}})
      return {sh[2*DW-1], {(DW-1){~sh[2*DW-1]}}};
`endif
    return sh[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] fx_add(
    input logic [DW-1:0] x, input logic [DW-1:0] y, input logic sub);
    logic [DW:0] s;
    s = sub ? {x[DW-1], x} - {y[DW-1], y}
            : {x[DW-1], x} + {y[DW-1], y};
`ifdef QEA_SATURATE_EN
    if (s[DW] != s[DW-1])
      return {s[DW], {(DW-1){~s[DW]}}};
`endif
    return s[DW-1:0];
  endfunction

  function automatic logic [SW-1:0] cmul(
    input logic [GW-1:0] u, input logic [SW-1:0] a);
    return {fx_add(fx_mul(u[GW-1:DW], a[SW-1:DW]),
                   fx_mul(u[DW-1:0], a[DW-1:0]), 1'b1),
            fx_add(fx_mul(u[GW-1:DW], a[DW-1:0]),
                   fx_mul(u[DW-1:0], a[SW-1:DW]), 1'b0)};
  endfunction

  function automatic logic [SW-1:0] cadd(
    input logic [SW-1:0] x, input logic [SW-1:0] y);
    return {fx_add(x[SW-1:DW], y[SW-1:DW], 1'b0),
            fx_add(x[DW-1:0], y[DW-1:0], 1'b0)};
  endfunction

  logic [LW-1:0] smem [2**AW];
  logic [CW-1:0] cmem [2**CA];

  st_t           st_q, st_d;
  logic [CA-1:0] pc_q, pc_d;
  logic [IW-1:0] pair_q, pair_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [GW-1:0] coef_q [4];
  logic [GW-1:0] coef_d [4];
  logic [GA-1:0] t_q, t_d, c_q, c_d;
  logic          cen_q, cen_d;
  logic [MQ-1:0] qn_q, qn_d;
  logic [LW-1:0] wb_word_q, wb_word_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic          complete_q, complete_d;
  logic [LW-1:0] dout_q;

  logic [CW-1:0] ctx_rd;
  logic [3:0]    hdr_op;
  logic          unused_hdr;
  logic          host_ok, gate_nop, skip, sweep_we, next_pair;
  logic [IW-1:0] i_idx, j_idx, half_m1;
  logic [AW-1:0] wa, wb;
  logic [PW-1:0] la, lb;
  logic [LW-1:0] word_a, word_b, new_a_word, new_b_word;
  logic [SW-1:0] amp_a, amp_b, na, nb;

  assign host_ok = (st_q == S_IDLE) || (st_q == S_DONE);
  assign ctx_rd = cmem[pc_q];
  assign hdr_op = ctx_rd[CW-1 -: 4];
  assign unused_hdr = ^ctx_rd[CW-6-2*GA:0];

  assign gate_nop = (t_q >= GA'(qn_q)) ||
                    (cen_q && ((c_q >= GA'(qn_q)) || (c_q == t_q)));

  // Pair p -> index i: insert a 0 at bit t of p.
  assign half_m1 = (IW'(1) << (qn_q - MQ'(1))) - IW'(1);
  assign i_idx = ((pair_q >> t_q) << (t_q + GA'(1))) |
                 (pair_q & ((IW'(1) << t_q) - IW'(1)));
  assign j_idx = i_idx | (IW'(1) << t_q);
  assign skip = cen_q && (((i_idx >> c_q) & IW'(1)) == '0);

  // Lane order is reversed: MSB lane holds the lowest index.
  assign wa = i_idx[IW-1:PW];
  assign wb = j_idx[IW-1:PW];
  assign la = PW'(PE_NUM-1) - i_idx[PW-1:0];
  assign lb = PW'(PE_NUM-1) - j_idx[PW-1:0];
  assign word_a = smem[wa];
  assign word_b = smem[wb];
  assign amp_a = word_a[la*SW +: SW];
  assign amp_b = word_b[lb*SW +: SW];
  assign na = cadd(cmul(coef_q[0], amp_a), cmul(coef_q[1], amp_b));
  assign nb = cadd(cmul(coef_q[2], amp_a), cmul(coef_q[3], amp_b));

  always_comb begin
    new_a_word = word_a;
    new_a_word[la*SW +: SW] = na;
    if (wa == wb) new_a_word[lb*SW +: SW] = nb;
    new_b_word = word_b;
    new_b_word[lb*SW +: SW] = nb;
  end

  always_comb begin
    st_d = st_q;
    pc_d = pc_q;
    pair_d = pair_q;
    cnt_d = cnt_q;
    coef_d = coef_q;
    t_d = t_q;
    c_d = c_q;
    cen_d = cen_q;
    qn_d = qn_q;
    wb_word_d = wb_word_q;
    wb_addr_d = wb_addr_q;
    complete_d = complete_q;
    sweep_we = 1'b0;
    next_pair = 1'b0;
    unique case (st_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          st_d = S_FETCH;
          pc_d = '0;
          qn_d = i_qbit_num;
          complete_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (hdr_op == 4'd0 || pc_q == '1) begin
          st_d = S_DONE;
          complete_d = 1'b1;
        end else begin
          pc_d = pc_q + CA'(1);
          if (hdr_op == 4'd1) begin
            t_d = ctx_rd[CW-5 -: GA];
            c_d = ctx_rd[CW-5-GA -: GA];
            cen_d = ctx_rd[CW-5-2*GA];
            cnt_d = '0;
            st_d = S_COEF;
          end
        end
      end
      S_COEF: begin
        coef_d[cnt_q] = ctx_rd;
        pc_d = pc_q + CA'(1);
        cnt_d = cnt_q + 2'd1;
        if (pc_q == '1) begin
          st_d = S_DONE;
          complete_d = 1'b1;
        end else if (cnt_q == 2'd3) begin
          pair_d = '0;
          st_d = gate_nop ? S_FETCH : S_SWEEP;
        end
      end
      S_SWEEP: begin
        sweep_we = !skip;
        if (!skip && wa != wb) begin
          wb_word_d = new_b_word;
          wb_addr_d = wb;
          st_d = S_WRB;
        end else begin
          next_pair = 1'b1;
        end
      end
      S_WRB: next_pair = 1'b1;
      default: st_d = S_IDLE;
    endcase
    if (next_pair) begin
      if (pair_q == half_m1) begin
        st_d = S_FETCH;
      end else begin
        pair_d = pair_q + IW'(1);
        st_d = S_SWEEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_IDLE;
      pc_q <= '0;
      pair_q <= '0;
      cnt_q <= '0;
      coef_q <= '{default: '0};
      t_q <= '0;
      c_q <= '0;
      cen_q <= 1'b0;
      qn_q <= '0;
      wb_word_q <= '0;
      wb_addr_q <= '0;
      complete_q <= 1'b0;
      dout_q <= '0;
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      pair_q <= pair_d;
      cnt_q <= cnt_d;
      coef_q <= coef_d;
      t_q <= t_d;
      c_q <= c_d;
      cen_q <= cen_d;
      qn_q <= qn_d;
      wb_word_q <= wb_word_d;
      wb_addr_q <= wb_addr_d;
      complete_q <= complete_d;
      if (host_ok && i_state_ena)
        dout_q <= smem[i_state_addra];
    end
  end

  always_ff @(posedge clk) begin
    if (host_ok && i_state_ena && i_state_wea)
      smem[i_state_addra] <= i_state_dina;
    if (!rst && sweep_we)
      smem[wa] <= new_a_word;
    if (!rst && st_q == S_WRB)
      smem[wb_addr_q] <= wb_word_q;
    if (host_ok && i_ctx_en && i_ctx_wea)
      cmem[i_ctx_addr] <= i_ctx_data;
  end

  assign o_complete = complete_q;
  assign o_state_dout = dout_q;
endmodule

// File: tb/tb_qea_core.sv
// tb_qea_core: directed self-checking bench for qea_core with an
// amplitude-array reference model and a readback compare process.
module tb_qea_core;
  localparam int QN = 11;
  localparam int NA = 1 << QN;
  localparam int NW = NA / 4;
  localparam logic [63:0] ONE = 64'h40000000_00000000;
  localparam logic [63:0] HC  = 64'h2D413CCD_00000000;
  localparam logic [63:0] HN  = 64'hD2BEC333_00000000;
  localparam logic [63:0] ZR  = 64'h0;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [5:0]   i_qbit_num;
  logic         i_ctx_en, i_ctx_wea;
  logic [15:0]  i_ctx_addr;
  logic [63:0]  i_ctx_data;
  logic         i_state_ena, i_state_wea;
  logic [15:0]  i_state_addra;
  logic [255:0] i_state_dina;
  logic         o_complete;
  logic [255:0] o_state_dout;

  qea_core dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_qbit_num(i_qbit_num),
    .i_ctx_en(i_ctx_en), .i_ctx_wea(i_ctx_wea),
    .i_ctx_addr(i_ctx_addr), .i_ctx_data(i_ctx_data),
    .i_state_ena(i_state_ena), .i_state_wea(i_state_wea),
    .i_state_addra(i_state_addra), .i_state_dina(i_state_dina),
    .o_complete(o_complete), .o_state_dout(o_state_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pc_w = 0;
  bit rb_phase = 1'b0;
  logic [63:0] amp [0:NA-1];

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] clamp(input longint v);
`ifdef QEA_SATURATE_EN
    if (v > 64'sd2147483647) return 32'h7FFFFFFF;
    if (v < -64'sd2147483648) return 32'h80000000;
`endif
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] x,
                                        input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return clamp(p >>> 30);
  endfunction

  function automatic logic [31:0] m_sum(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input bit neg);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return clamp(neg ? sx - sy : sx + sy);
  endfunction

  // (ur + j ui)(ar + j ai)
  function automatic logic [63:0] m_cmul(input logic [63:0] u,
                                         input logic [63:0] a);
    logic [31:0] re, im;
    re = m_sum(m_mul(u[63:32], a[63:32]), m_mul(u[31:0], a[31:0]), 1);
    im = m_sum(m_mul(u[63:32], a[31:0]), m_mul(u[31:0], a[63:32]), 0);
    return {re, im};
  endfunction

  function automatic logic [63:0] m_cadd(input logic [63:0] x,
                                         input logic [63:0] y);
    return {m_sum(x[63:32], y[63:32], 0), m_sum(x[31:0], y[31:0], 0)};
  endfunction

  function automatic logic [255:0] model_word(input int w);
    if (w < 0 || w >= NW) return '0;
    return {amp[4*w], amp[4*w+1], amp[4*w+2], amp[4*w+3]};
  endfunction

  task automatic m_gate(input int t, input int c, input bit cen,
                        input logic [63:0] u0, input logic [63:0] u1,
                        input logic [63:0] u2, input logic [63:0] u3);
    logic [63:0] a, b;
    int j;
    if (t >= QN) return;
    if (cen && (c >= QN || c == t)) return;
    for (int i = 0; i < NA; i++) begin
      if (((i >> t) & 1) == 0 && (!cen || ((i >> c) & 1) == 1)) begin
        j = i | (1 << t);
        a = amp[i];
        b = amp[j];
        amp[i] = m_cadd(m_cmul(u0, a), m_cmul(u1, b));
        amp[j] = m_cadd(m_cmul(u2, a), m_cmul(u3, b));
      end
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < NA; i++) amp[i] = '0;
    amp[0] = ONE;
  endtask

  // Readback compare: every host read is checked against the model.
  logic         exp_v = 1'b0;
  logic [255:0] exp_w = '0;
  always @(posedge clk) begin
    exp_v <= rb_phase && i_state_ena && !i_state_wea;
    exp_w <= model_word(int'(i_state_addra));
  end
  always @(negedge clk) begin
    if (exp_v) chk("rdback", o_state_dout, exp_w);
  end

  task automatic load_state();
    for (int w = 0; w < NW; w++) begin
      @(negedge clk);
      i_state_ena = 1; i_state_wea = 1;
      i_state_addra = 16'(w); i_state_dina = model_word(w);
    end
    @(negedge clk);
    i_state_ena = 0; i_state_wea = 0;
  endtask

  task automatic readback();
    rb_phase = 1;
    for (int w = 0; w < NW; w++) begin
      @(negedge clk);
      i_state_ena = 1; i_state_wea = 0; i_state_addra = 16'(w);
    end
    @(negedge clk);
    i_state_ena = 0;
    @(negedge clk);
    rb_phase = 0;
  endtask

  task automatic rd_lit(input string nm, input int w,
                        input logic [255:0] lit);
    rb_phase = 1;
    @(negedge clk);
    i_state_ena = 1; i_state_wea = 0; i_state_addra = 16'(w);
    @(negedge clk);
    i_state_ena = 0;
    chk(nm, o_state_dout, lit);
    rb_phase = 0;
  endtask

  task automatic cw(input logic [63:0] d);
    @(negedge clk);
    i_ctx_en = 1; i_ctx_wea = 1;
    i_ctx_addr = 16'(pc_w); i_ctx_data = d;
    pc_w++;
  endtask

  task automatic put_gate(input int t, input int c, input bit cen,
                          input logic [63:0] u0, input logic [63:0] u1,
                          input logic [63:0] u2, input logic [63:0] u3);
    cw({4'h1, 6'(t), 6'(c), cen, 47'h0});
    cw(u0); cw(u1); cw(u2); cw(u3);
    m_gate(t, c, cen, u0, u1, u2, u3);
  endtask

  task automatic put_end();
    cw(64'h0);
    @(negedge clk);
    i_ctx_en = 0; i_ctx_wea = 0;
    pc_w = 0;
  endtask

  task automatic start_prog();
    @(negedge clk);
    i_start = 1;
    @(negedge clk);
    i_start = 0;
  endtask

  task automatic run(input string nm);
    int cyc;
    start_prog();
    chk({nm, "_clr"}, 256'(o_complete), 256'(0));
    // host write while running must be dropped
    i_state_ena = 1; i_state_wea = 1; i_state_addra = 16'd5;
    i_state_dina = {8{32'hDEADBEEF}};
    @(negedge clk);
    i_state_ena = 0; i_state_wea = 0;
    cyc = 0;
    while (!o_complete && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_done"}, 256'(o_complete), 256'(1));
  endtask

  initial begin
    logic [63:0] gain_a;
    rst = 1; i_start = 0; i_qbit_num = 6'(QN);
    i_ctx_en = 0; i_ctx_wea = 0; i_ctx_addr = 0; i_ctx_data = 0;
    i_state_ena = 0; i_state_wea = 0; i_state_addra = 0;
    i_state_dina = 0;
    repeat (3) @(negedge clk);
    chk("rst_complete", 256'(o_complete), 256'(0));
    chk("rst_dout", o_state_dout, 256'(0));
    rst = 0;

    // END only
    model_zero(); load_state();
    put_end();
    run("end");
    readback();
    rd_lit("end_w0", 0, {ONE, ZR, ZR, ZR});

    // Hadamard on qubit 0
    model_zero(); load_state();
    put_gate(0, 0, 0, HC, HC, HC, HN);
    put_end();
    run("h");
    readback();
    rd_lit("h_w0", 0, {HC, HC, ZR, ZR});
    rd_lit("h_w1", 1, 256'(0));

    // X on qubit 10, plus NOP header and gates that must be NOPs
    model_zero(); load_state();
    cw({4'h3, 60'h0});
    put_gate(20, 0, 0, ZR, ONE, ONE, ZR);
    put_gate(1, 1, 1, ZR, ONE, ONE, ZR);
    put_gate(10, 0, 0, ZR, ONE, ONE, ZR);
    put_gate(2, 15, 1, ZR, ONE, ONE, ZR);
    put_end();
    run("x10");
    readback();
    rd_lit("x10_w256", 256, {ONE, ZR, ZR, ZR});
    rd_lit("x10_w0", 0, 256'(0));

    // CNOT on |0> leaves state alone
    model_zero(); load_state();
    put_gate(1, 0, 1, ZR, ONE, ONE, ZR);
    put_end();
    run("cnot");
    readback();
    rd_lit("cnot_w0", 0, {ONE, ZR, ZR, ZR});

    // Bell pair
    model_zero(); load_state();
    put_gate(0, 0, 0, HC, HC, HC, HN);
    put_gate(1, 0, 1, ZR, ONE, ONE, ZR);
    put_end();
    run("bell");
    readback();
    rd_lit("bell_w0", 0, {HC, ZR, ZR, HC});

    // Reset mid-run, then reload and rerun
    model_zero(); load_state();
    put_gate(0, 0, 0, HC, HC, HC, HN);
    put_gate(3, 0, 0, HC, HC, HC, HN);
    put_gate(7, 0, 0, HC, HC, HC, HN);
    put_gate(10, 0, 1, ZR, ONE, ONE, ZR);
    put_gate(0, 0, 0, HC, HC, HC, HN);
    put_end();
    start_prog();
    repeat (40) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_complete", 256'(o_complete), 256'(0));
    chk("mid_rst_dout", o_state_dout, 256'(0));
    @(negedge clk);
    chk("mid_rst_hold", 256'(o_complete), 256'(0));
    rst = 0;
    model_zero(); load_state();
    put_gate(0, 0, 0, HC, HC, HC, HN);
    put_gate(3, 0, 0, HC, HC, HC, HN);
    put_gate(7, 0, 0, HC, HC, HC, HN);
    put_gate(10, 0, 1, ZR, ONE, ONE, ZR);
    put_gate(0, 0, 0, HC, HC, HC, HN);
    put_end();
    run("rerun");
    readback();

    // Gain 2.0 on the real part overflows
`ifdef QEA_SATURATE_EN
    gain_a = 64'h7FFFFFFF_00000000;
`else
    gain_a = 64'h80000000_00000000;
`endif
    model_zero();
    amp[1] = ONE;
    load_state();
    put_gate(0, 0, 0, ONE, ONE, ZR, ONE);
    put_end();
    run("gain");
    readback();
    rd_lit("gain_w0", 0, {gain_a, ONE, ZR, ZR});

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
